// File: rtl/push_to_axis_mux_pkg.sv
// rtl/push_to_axis_mux_pkg.sv - shared sizing helpers for multi-channel stream blocks
// Purpose: constant functions used to size channel tags.
//   clog2(value)         : ceiling log2, 0 for value <= 1
//   chan_width(channels) : tag width, never narrower than one bit
package push_to_axis_mux_pkg;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result = result + 1;
    end
    return result;
  endfunction

  // A single-channel block still carries a 1-bit tag so port widths stay legal.
  function automatic int chan_width(input int channels);
    return (channels > 1) ? clog2(channels) : 1;
  endfunction

endpackage

// File: rtl/push_to_axis_mux_if.sv
// rtl/push_to_axis_mux_if.sv - push inputs, status and output stream bundle
// Purpose: groups every non-clock signal of push_to_axis_mux.
//   idata/ienable          : per-channel push data and strobe
//   iafull                 : per-channel almost-full
//   overflow_clear         : clears overflow flags and drop counters
//   overflow/drops         : per-channel sticky flag and saturating drop count
//   odata/ochan/ovalid     : merged stream word, its source channel, valid
//   oready                 : stream ready from the consumer
// master = the mux itself, slave = the push sources plus stream consumer.
interface push_to_axis_mux_if
  import push_to_axis_mux_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int CHANNELS   = 2,
  parameter int DROP_WIDTH = 8,
  parameter int CHAN_WIDTH = chan_width(CHANNELS)
);
  logic [CHANNELS*DATA_WIDTH-1:0] idata;
  logic [CHANNELS-1:0]            ienable;
  logic [CHANNELS-1:0]            iafull;
  logic                           overflow_clear;
  logic [CHANNELS-1:0]            overflow;
  logic [CHANNELS*DROP_WIDTH-1:0] drops;
  logic [DATA_WIDTH-1:0]          odata;
  logic [CHAN_WIDTH-1:0]          ochan;
  logic                           ovalid;
  logic                           oready;

  modport master (
    input  idata, ienable, overflow_clear, oready,
    output iafull, overflow, drops, odata, ochan, ovalid
  );

  modport slave (
    output idata, ienable, overflow_clear, oready,
    input  iafull, overflow, drops, odata, ochan, ovalid
  );
endinterface

// File: rtl/push_to_axis_mux_push_fifo_chan.sv
// rtl/push_to_axis_mux_push_fifo_chan.sv - single-channel push FIFO with drop accounting
// Purpose: one channel of the mux. Pushes never stall; a push into a full FIFO
// is dropped unless the same cycle pops, in which case it is accepted.
//   clock/reset        : rising-edge clock, synchronous active-high reset
//   overflow_clear_i   : clears overflow_o and drops_o (a same-cycle drop wins)
//   push_i/data_i      : push strobe and data
//   pop_i              : remove head word (only asserted when not empty)
//   head_o/empty_o     : combinational head word, FIFO empty
//   afull_o            : registered almost-full, from the post-update count
//   overflow_o/drops_o : sticky overflow flag, saturating drop counter
module push_fifo_chan #(
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 4,
  parameter int AFULL_LIMIT = 2**(ADDR_WIDTH-1),
  parameter int DROP_WIDTH  = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  overflow_clear_i,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] head_o,
  output logic                  empty_o,
  output logic                  afull_o,
  output logic                  overflow_o,
  output logic [DROP_WIDTH-1:0] drops_o
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AFULL_C = (ADDR_WIDTH+1)'(AFULL_LIMIT);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_q, rd_ptr_q;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  afull_q, overflow_q, overflow_d;
  logic [DROP_WIDTH-1:0] drops_q, drops_d;
  logic                  accept_w, drop_w;

  always_comb begin
    // A pop in the same cycle frees the slot the push needs.
    accept_w   = push_i && ((count_q != DEPTH_C) || pop_i);
    drop_w     = push_i && !accept_w;
    count_d    = count_q + {{ADDR_WIDTH{1'b0}}, accept_w} - {{ADDR_WIDTH{1'b0}}, pop_i};
    overflow_d = overflow_q;
    drops_d    = drops_q;
    if (overflow_clear_i) begin
      overflow_d = 1'b0;
      drops_d    = '0;
    end
    if (drop_w) begin
      overflow_d = 1'b1;
      if (overflow_clear_i) begin
        drops_d = DROP_WIDTH'(1);
      end else if (drops_q != {DROP_WIDTH{1'b1}}) begin
        drops_d = drops_q + DROP_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (accept_w) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      afull_q    <= 1'b1;
      overflow_q <= 1'b0;
      drops_q    <= '0;
    end else begin
      if (accept_w) wr_ptr_q <= wr_ptr_q + ADDR_WIDTH'(1);
      if (pop_i)    rd_ptr_q <= rd_ptr_q + ADDR_WIDTH'(1);
      count_q    <= count_d;
      afull_q    <= (count_d >= AFULL_C);
      overflow_q <= overflow_d;
      drops_q    <= drops_d;
    end
  end

  assign head_o     = mem_q[rd_ptr_q];
  assign empty_o    = (count_q == '0);
  assign afull_o    = afull_q;
  assign overflow_o = overflow_q;
  assign drops_o    = drops_q;
endmodule

// File: rtl/push_to_axis_mux.sv
// rtl/push_to_axis_mux.sv - round-robin merge of per-channel push FIFOs into one tagged stream
// Purpose: CHANNELS push sources each fill a private FIFO; a round-robin
// arbiter pops one word per cycle into a registered stream with a channel tag.
//   clock/reset : rising-edge clock, synchronous active-high reset
//   bus         : push_to_axis_mux_if master (push inputs, status, stream)
module push_to_axis_mux
  import push_to_axis_mux_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 4,
  parameter int CHANNELS    = 2,
  parameter int AFULL_LIMIT = 2**(ADDR_WIDTH-1),
  parameter int DROP_WIDTH  = 8
) (
  input  logic               clock,
  input  logic               reset,
  push_to_axis_mux_if.master bus
);
  localparam int CHAN_WIDTH = chan_width(CHANNELS);

  logic [CHANNELS-1:0]            empty_w, pop_w, iafull_w, overflow_w;
  logic [CHANNELS*DROP_WIDTH-1:0] drops_w;
  logic [DATA_WIDTH-1:0]          head_w [CHANNELS];
  logic [DATA_WIDTH-1:0]          head_sel_w;
  logic [CHAN_WIDTH-1:0]          grant_w;
  logic                           any_w, load_w;

  logic [CHAN_WIDTH-1:0] ptr_q, ptr_d;
  logic [DATA_WIDTH-1:0] odata_q, odata_d;
  logic [CHAN_WIDTH-1:0] ochan_q, ochan_d;
  logic                  ovalid_q, ovalid_d;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    push_fifo_chan #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .AFULL_LIMIT(AFULL_LIMIT),
      .DROP_WIDTH (DROP_WIDTH)
    ) u_chan (
      .clock           (clock),
      .reset           (reset),
      .overflow_clear_i(bus.overflow_clear),
      .push_i          (bus.ienable[c]),
      .data_i          (bus.idata[c*DATA_WIDTH +: DATA_WIDTH]),
      .pop_i           (pop_w[c]),
      .head_o          (head_w[c]),
      .empty_o         (empty_w[c]),
      .afull_o         (iafull_w[c]),
      .overflow_o      (overflow_w[c]),
      .drops_o         (drops_w[c*DROP_WIDTH +: DROP_WIDTH])
    );
  end

  // Round-robin search from ptr+1 upward with wrap: first try channels above
  // the last grant, then wrap around to channels at or below it.
  always_comb begin
    any_w      = 1'b0;
    grant_w    = '0;
    head_sel_w = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (!any_w && !empty_w[c] && (c > int'(ptr_q))) begin
        any_w      = 1'b1;
        grant_w    = CHAN_WIDTH'(c);
        head_sel_w = head_w[c];
      end
    end
    for (int c = 0; c < CHANNELS; c++) begin
      if (!any_w && !empty_w[c] && (c <= int'(ptr_q))) begin
        any_w      = 1'b1;
        grant_w    = CHAN_WIDTH'(c);
        head_sel_w = head_w[c];
      end
    end
  end

  always_comb begin
    load_w   = (!ovalid_q || bus.oready) && any_w;
    ptr_d    = ptr_q;
    odata_d  = odata_q;
    ochan_d  = ochan_q;
    ovalid_d = ovalid_q;
    for (int c = 0; c < CHANNELS; c++) begin
      pop_w[c] = load_w && (grant_w == CHAN_WIDTH'(c));
    end
    if (load_w) begin
      ptr_d    = grant_w;
      odata_d  = head_sel_w;
      ochan_d  = grant_w;
      ovalid_d = 1'b1;
    end else if (bus.oready) begin
      ovalid_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ptr_q    <= CHAN_WIDTH'(CHANNELS-1);
      odata_q  <= '0;
      ochan_q  <= '0;
      ovalid_q <= 1'b0;
    end else begin
      ptr_q    <= ptr_d;
      odata_q  <= odata_d;
      ochan_q  <= ochan_d;
      ovalid_q <= ovalid_d;
    end
  end

  assign bus.iafull   = iafull_w;
  assign bus.overflow = overflow_w;
  assign bus.drops    = drops_w;
  assign bus.odata    = odata_q;
  assign bus.ochan    = ochan_q;
  assign bus.ovalid   = ovalid_q;
endmodule

// File: tb/tb_push_to_axis_mux.sv
// tb/tb_push_to_axis_mux.sv - self-checking bench for push_to_axis_mux
module tb_push_to_axis_mux;
  localparam int DW = 8;
  localparam int CH = 2;
  localparam int DEPTH = 16;
  localparam int AFL = 8;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  push_to_axis_mux_if #(.DATA_WIDTH(8), .CHANNELS(2), .DROP_WIDTH(8)) bus ();
  push_to_axis_mux_if #(.DATA_WIDTH(8), .CHANNELS(2), .DROP_WIDTH(2)) bus2 ();

  push_to_axis_mux dut (.clock(clock), .reset(reset), .bus(bus));
  push_to_axis_mux #(.DROP_WIDTH(2)) dut2 (.clock(clock), .reset(reset), .bus(bus2));

  int errors = 0;
  int checks = 0;

  // Reference model for dut: queues per channel plus the output word.
  logic [7:0] mq [CH][$];
  bit         m_valid;
  logic [7:0] m_data;
  int         m_chan, m_ptr;
  bit         m_ovf [CH];
  int         m_drops [CH];
  bit         m_afull [CH];

  typedef struct {
    logic [1:0]  ien;
    logic [15:0] idata;
    logic        ordy;
    logic        exp_valid;
    logic [7:0]  exp_data;
    logic        exp_chan;
  } vec_t;
  vec_t tbl [13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_tick();
    int g;
    bit load;
    bit drop [CH];
    if (reset) begin
      for (int c = 0; c < CH; c++) begin
        mq[c].delete();
        m_ovf[c] = 0; m_drops[c] = 0; m_afull[c] = 1;
      end
      m_valid = 0; m_data = 0; m_chan = 0; m_ptr = CH - 1;
      return;
    end
    g = -1;
    for (int k = 1; k <= CH; k++)
      if (g < 0 && mq[(m_ptr + k) % CH].size() > 0) g = (m_ptr + k) % CH;
    load = (!m_valid || bus.oready) && (g >= 0);
    for (int c = 0; c < CH; c++)
      drop[c] = bus.ienable[c] && (mq[c].size() >= DEPTH) && !(load && g == c);
    if (load) begin
      m_data = mq[g].pop_front(); m_chan = g; m_valid = 1; m_ptr = g;
    end else if (bus.oready) begin
      m_valid = 0;
    end
    for (int c = 0; c < CH; c++) begin
      if (bus.ienable[c] && !drop[c]) mq[c].push_back(bus.idata[c*DW +: DW]);
      if (drop[c]) begin
        m_ovf[c] = 1;
        m_drops[c] = bus.overflow_clear ? 1 : ((m_drops[c] < 255) ? m_drops[c] + 1 : 255);
      end else if (bus.overflow_clear) begin
        m_ovf[c] = 0; m_drops[c] = 0;
      end
      m_afull[c] = (mq[c].size() >= AFL);
    end
  endtask

  task automatic step();
    model_tick();
    @(posedge clock);
    #1;
  endtask

  task automatic compare_model();
    chk("model ovalid", bus.ovalid, m_valid);
    if (m_valid) begin
      chk("model odata", bus.odata, m_data);
      chk("model ochan", bus.ochan, m_chan);
    end
    chk("model iafull", bus.iafull, {m_afull[1], m_afull[0]});
    chk("model overflow", bus.overflow, {m_ovf[1], m_ovf[0]});
    chk("model drops0", bus.drops[7:0], m_drops[0]);
    chk("model drops1", bus.drops[15:8], m_drops[1]);
  endtask

  initial begin
    logic [7:0] got [$];
    tbl[0]  = '{2'b10, 16'hA500, 1'b1, 1'b0, 8'h00, 1'b0};
    tbl[1]  = '{2'b00, 16'h0000, 1'b1, 1'b1, 8'hA5, 1'b1};
    tbl[2]  = '{2'b00, 16'h0000, 1'b1, 1'b0, 8'h00, 1'b0};
    tbl[3]  = '{2'b11, 16'h1000, 1'b1, 1'b0, 8'h00, 1'b0};
    tbl[4]  = '{2'b11, 16'h1101, 1'b1, 1'b1, 8'h00, 1'b0};
    tbl[5]  = '{2'b11, 16'h1202, 1'b1, 1'b1, 8'h10, 1'b1};
    tbl[6]  = '{2'b11, 16'h1303, 1'b1, 1'b1, 8'h01, 1'b0};
    tbl[7]  = '{2'b00, 16'h0000, 1'b1, 1'b1, 8'h11, 1'b1};
    tbl[8]  = '{2'b00, 16'h0000, 1'b1, 1'b1, 8'h02, 1'b0};
    tbl[9]  = '{2'b00, 16'h0000, 1'b1, 1'b1, 8'h12, 1'b1};
    tbl[10] = '{2'b00, 16'h0000, 1'b1, 1'b1, 8'h03, 1'b0};
    tbl[11] = '{2'b00, 16'h0000, 1'b1, 1'b1, 8'h13, 1'b1};
    tbl[12] = '{2'b00, 16'h0000, 1'b1, 1'b0, 8'h00, 1'b0};

    reset = 1'b1;
    bus.idata = '0; bus.ienable = '0; bus.oready = 1'b0; bus.overflow_clear = 1'b0;
    bus2.idata = '0; bus2.ienable = '0; bus2.oready = 1'b1; bus2.overflow_clear = 1'b0;
    step(); step();
    chk("rst ovalid", bus.ovalid, 0);
    chk("rst odata", bus.odata, 0);
    chk("rst ochan", bus.ochan, 0);
    chk("rst iafull", bus.iafull, 2'b11);
    chk("rst overflow", bus.overflow, 0);
    chk("rst drops", bus.drops, 0);
    reset = 1'b0;

    // Directed table: single push latency, then interleaved two-channel burst.
    for (int i = 0; i < 13; i++) begin
      bus.ienable = tbl[i].ien; bus.idata = tbl[i].idata; bus.oready = tbl[i].ordy;
      step();
      chk($sformatf("tbl%0d ovalid", i), bus.ovalid, tbl[i].exp_valid);
      if (tbl[i].exp_valid) begin
        chk($sformatf("tbl%0d odata", i), bus.odata, tbl[i].exp_data);
        chk($sformatf("tbl%0d ochan", i), bus.ochan, tbl[i].exp_chan);
      end
    end
    chk("burst overflow", bus.overflow, 0);

    // Fill ch0 with oready low: 16 stored, 1 in output register, 3 dropped.
    bus.oready = 1'b0; bus.ienable = 2'b01;
    for (int i = 0; i < 20; i++) begin
      bus.idata = {8'h00, 8'(8'h40 + i)};
      step();
      if (i == 7) chk("iafull at count 7", bus.iafull[0], 0);
      if (i == 8) chk("iafull at count 8", bus.iafull[0], 1);
      compare_model();
    end
    bus.ienable = 2'b00;
    chk("fill overflow0", bus.overflow[0], 1);
    chk("fill drops0", bus.drops[7:0], 3);
    chk("fill drops1", bus.drops[15:8], 0);
    chk("fill hold odata", bus.odata, 8'h40);
    // Full FIFO, push coincident with a pop: accepted, no drop.
    bus.ienable = 2'b01; bus.idata = 16'h0099; bus.oready = 1'b1;
    step();
    chk("simul drops0", bus.drops[7:0], 3);
    chk("simul odata", bus.odata, 8'h41);
    chk("simul iafull0", bus.iafull[0], 1);
    bus.ienable = 2'b00;
    for (int cyc = 0; cyc < 40 && got.size() < 17; cyc++) begin
      if (bus.ovalid && bus.oready) got.push_back(bus.odata);
      step();
    end
    chk("drain count", got.size(), 17);
    for (int i = 0; i < 17 && i < got.size(); i++)
      chk($sformatf("drain word%0d", i), got[i], (i < 16) ? 8'(8'h41 + i) : 8'h99);
    bus.overflow_clear = 1'b1;
    step();
    bus.overflow_clear = 1'b0;
    chk("clear overflow", bus.overflow, 0);
    chk("clear drops", bus.drops, 0);

    // DROP_WIDTH=2 instance: saturation and clear/drop priority.
    bus2.oready = 1'b0; bus2.ienable = 2'b01;
    for (int i = 0; i < 22; i++) begin
      bus2.idata = {8'h00, 8'(i)};
      step();
    end
    bus2.ienable = 2'b00;
    chk("sat drops", bus2.drops[1:0], 3);
    chk("sat overflow", bus2.overflow[0], 1);
    bus2.overflow_clear = 1'b1;
    step();
    chk("sat clear drops", bus2.drops[1:0], 0);
    chk("sat clear overflow", bus2.overflow[0], 0);
    bus2.ienable = 2'b01;
    step();
    bus2.ienable = 2'b00; bus2.overflow_clear = 1'b0;
    chk("clr+drop overflow", bus2.overflow[0], 1);
    chk("clr+drop drops", bus2.drops[1:0], 1);
    step();
    chk("after clr+drop drops", bus2.drops[1:0], 1);
    bus2.oready = 1'b1;

    // Randomised traffic against the model.
    for (int i = 0; i < 400; i++) begin
      bus.ienable = 2'($urandom_range(0, 3));
      bus.idata = 16'($urandom);
      bus.oready = ($urandom_range(0, 99) < 45);
      bus.overflow_clear = ($urandom_range(0, 99) < 3);
      step();
      compare_model();
    end

    // Reset mid-stream with a pending output word.
    bus.overflow_clear = 1'b0; bus.oready = 1'b0; bus.ienable = 2'b10; bus.idata = 16'h7700;
    step(); step(); step();
    chk("pre-reset ovalid", bus.ovalid, 1);
    reset = 1'b1; bus.ienable = 2'b11;
    step();
    reset = 1'b0; bus.ienable = 2'b00; bus.oready = 1'b1;
    chk("mid-reset ovalid", bus.ovalid, 0);
    chk("mid-reset iafull", bus.iafull, 2'b11);
    chk("mid-reset overflow", bus.overflow, 0);
    step();
    chk("post-reset empty", bus.ovalid, 0);
    bus.ienable = 2'b11; bus.idata = 16'h6B5A;
    step();
    bus.ienable = 2'b00;
    step();
    chk("post-reset grant valid", bus.ovalid, 1);
    chk("post-reset grant ochan", bus.ochan, 0);
    chk("post-reset grant odata", bus.odata, 8'h5A);
    step();
    chk("post-reset 2nd ochan", bus.ochan, 1);
    chk("post-reset 2nd odata", bus.odata, 8'h6B);
    compare_model();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
